// File: rtl/alu_bist.sv
// Built-in self test sequencer for a combinational ALU: drives LFSR operand
// vectors across every opcode and compresses the ALU results into a MISR signature.
module alu_bist #(
  parameter int               WIDTH   = 16,
  parameter int               N_OPS   = 7,
  parameter int               VECTORS = 16,
  parameter logic [WIDTH-1:0] SEED_A  = 16'hACE1,
  parameter logic [WIDTH-1:0] SEED_B  = 16'h1D2C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature
);

  localparam int            CW       = (VECTORS > 1) ? $clog2(VECTORS) : 1;
  localparam logic [CW-1:0] LAST_VEC = CW'(VECTORS - 1);
  localparam logic [2:0]    LAST_OP  = 3'(N_OPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    vec_cnt, vec_cnt_next;
  logic [WIDTH-1:0] a_next, b_next, sig_next;
  logic [2:0]       op_next;

  // Shared by the operand LFSRs and the MISR; taps 16,14,13,11
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1] ^ x[WIDTH-3] ^ x[WIDTH-4] ^ x[WIDTH-6]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    a_next       = alu_a;
    b_next       = alu_b;
    op_next      = alu_op;
    sig_next     = signature;
    vec_cnt_next = vec_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next   = RUN;
          a_next       = SEED_A;
          b_next       = SEED_B;
          op_next      = '0;
          sig_next     = '0;
          vec_cnt_next = '0;
        end
      end
      RUN: begin
        sig_next = lfsr_step(signature) ^ alu_res;
        if (vec_cnt == LAST_VEC) begin
          vec_cnt_next = '0;
          // Last opcode finished: operands and opcode hold for inspection
          if (alu_op == LAST_OP) begin
            state_next = DONE;
          end else begin
            op_next = alu_op + 3'd1;
            a_next  = SEED_A;
            b_next  = SEED_B;
          end
        end else begin
          vec_cnt_next = vec_cnt + CW'(1);
          a_next       = lfsr_step(alu_a);
          b_next       = lfsr_step(alu_b);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      signature <= '0;
      vec_cnt   <= '0;
    end else begin
      alu_a     <= a_next;
      alu_b     <= b_next;
      alu_op    <= op_next;
      signature <= sig_next;
      vec_cnt   <= vec_cnt_next;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
